// File: rtl/scancode_to_ascii_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code to ASCII decoder.
package scancode_to_ascii_pkg;

  // Prefix tracking: which prefix bytes of the current sequence have been seen.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  // Prefix bytes
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;

  // Non-extended scan codes
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Extended scan codes (follow an E0 prefix)
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  // ASCII results
  localparam logic [6:0] ASCII_NONE  = 7'h00;
  localparam logic [6:0] ASCII_A     = 7'h61;
  localparam logic [6:0] ASCII_D     = 7'h64;
  localparam logic [6:0] ASCII_W     = 7'h77;
  localparam logic [6:0] ASCII_S     = 7'h73;
  localparam logic [6:0] ASCII_SPACE = 7'h20;

endpackage

// File: rtl/scancode_to_ascii_scan_lut.sv
// Combinational key map: {extended flag, scan code} -> {hit, ascii}.
// Arrow keys alias onto the WASD characters.
module scan_lut
  import scancode_to_ascii_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  output logic       o_hit,
  output logic [6:0] o_ascii
);

  // Table lookup; anything not listed is a miss with a zero code.
  always_comb begin
    o_hit   = 1'b0;
    o_ascii = ASCII_NONE;
    case ({i_ext, i_code})
      {1'b0, SC_A}:     begin o_hit = 1'b1; o_ascii = ASCII_A;     end
      {1'b0, SC_D}:     begin o_hit = 1'b1; o_ascii = ASCII_D;     end
      {1'b0, SC_W}:     begin o_hit = 1'b1; o_ascii = ASCII_W;     end
      {1'b0, SC_S}:     begin o_hit = 1'b1; o_ascii = ASCII_S;     end
      {1'b0, SC_SPACE}: begin o_hit = 1'b1; o_ascii = ASCII_SPACE; end
      {1'b1, SC_LEFT}:  begin o_hit = 1'b1; o_ascii = ASCII_A;     end
      {1'b1, SC_RIGHT}: begin o_hit = 1'b1; o_ascii = ASCII_D;     end
      {1'b1, SC_UP}:    begin o_hit = 1'b1; o_ascii = ASCII_W;     end
      {1'b1, SC_DOWN}:  begin o_hit = 1'b1; o_ascii = ASCII_S;     end
      default:          begin o_hit = 1'b0; o_ascii = ASCII_NONE;  end
    endcase
  end

endmodule

// File: rtl/scancode_to_ascii.sv
// PS/2 set-2 decoder: tracks E0/F0 prefixes, holds the ASCII code of the
// last pressed mapped key and pulses ascii_new whenever that code is
// (re)loaded or cleared.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | no prefix pending; next byte is a make code
// EXT      | E0 seen; next byte is an extended make
// BRK      | F0 seen; next byte is a break code
// EXT_BRK  | E0 F0 seen; next byte is an extended break
module scancode_to_ascii
  import scancode_to_ascii_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [6:0] ascii_out,
  output logic       ascii_new
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_ascii;
  logic             r_new;

  logic             w_ext;
  logic             w_brk;
  logic             w_hit;
  logic [6:0]       w_ascii;

  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_brk = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);

  scan_lut u_scan_lut (
    .i_ext   (w_ext),
    .i_code  (scan_code),
    .o_hit   (w_hit),
    .o_ascii (w_ascii)
  );

  // Sequence FSM, prefix timeout and registered key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ascii <= ASCII_NONE;
      r_new   <= 1'b0;
    end else begin
      r_new <= 1'b0;
      if (scan_valid) begin
        // A strobe always restarts the timeout and beats a coincident expiry.
        r_cnt <= '0;
        case (scan_code)
          // E0 is only legal from IDLE; elsewhere it restarts a fresh
          // sequence, which lands in EXT either way.
          SC_E0: r_state <= ST_EXT;
          // F0 after a lone E0 continues an extended break; any other
          // misplaced F0 restarts as a plain break.
          SC_F0: r_state <= (r_state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
          default: begin
            r_state <= ST_IDLE;
            if (w_hit) begin
              if (!w_brk) begin
                r_ascii <= w_ascii;
                r_new   <= 1'b1;
              end else if (w_ascii == r_ascii) begin
                r_ascii <= ASCII_NONE;
                r_new   <= 1'b1;
              end
            end
          end
        endcase
      end else if (r_state != ST_IDLE) begin
        if (r_cnt == CNT_LAST) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  assign ascii_out = r_ascii;
  assign ascii_new = r_new;

endmodule

// File: tb/tb_scancode_to_ascii.sv
// Self-checking bench: directed vector table, hand-written timeout
// sequences, then random traffic compared against a prefix-queue model.
module tb_scancode_to_ascii;

  localparam int TMO = 16;

  logic       clk;
  logic       rst;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [6:0] ascii_out;
  logic       ascii_new;

  int vectors     = 0;
  int miscompares = 0;

  scancode_to_ascii #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .ascii_out  (ascii_out),
    .ascii_new  (ascii_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] keymap [int];
  logic [7:0] pending [$];
  int         idle_cnt;
  logic [6:0] m_out;
  bit         m_new;

  task automatic model_step(input bit r, input bit v, input logic [7:0] c);
    bit ext, brk, legal;
    int key;
    if (r) begin
      pending.delete();
      idle_cnt = 0;
      m_out    = 7'h00;
      m_new    = 1'b0;
      return;
    end
    m_new = 1'b0;
    if (v) begin
      idle_cnt = 0;
      if (c == 8'hE0 || c == 8'hF0) begin
        legal = (pending.size() == 0) ||
                (pending.size() == 1 && pending[0] == 8'hE0 && c == 8'hF0);
        if (!legal) pending.delete();
        pending.push_back(c);
      end else begin
        ext = 1'b0;
        brk = 1'b0;
        foreach (pending[i]) begin
          if (pending[i] == 8'hE0) ext = 1'b1;
          if (pending[i] == 8'hF0) brk = 1'b1;
        end
        pending.delete();
        key = (ext ? 256 : 0) + int'(c);
        if (keymap.exists(key)) begin
          if (!brk) begin
            m_out = keymap[key];
            m_new = 1'b1;
          end else if (keymap[key] == m_out) begin
            m_out = 7'h00;
            m_new = 1'b1;
          end
        end
      end
    end else if (pending.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TMO) begin
        pending.delete();
        idle_cnt = 0;
      end
    end
  endtask

  // ---------------- drive / check ----------------
  task automatic drive(input bit r, input bit v, input logic [7:0] c);
    @(negedge clk);
    rst        = r;
    scan_valid = v;
    scan_code  = c;
    @(posedge clk);
    model_step(r, v, c);
    #1;
  endtask

  task automatic check(input string nm, input logic [6:0] eo, input bit en);
    vectors++;
    if (ascii_out !== eo || ascii_new !== en) begin
      miscompares++;
      $display("FAIL %s: ascii_out=%h ascii_new=%b, expected ascii_out=%h ascii_new=%b",
               nm, ascii_out, ascii_new, eo, en);
    end
  endtask

  task automatic step(input string nm, input bit v, input logic [7:0] c,
                      input logic [6:0] eo, input bit en);
    drive(1'b0, v, c);
    check(nm, eo, en);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         r;
    bit         v;
    logic [7:0] c;
    logic [6:0] eo;
    bit         en;
    string      nm;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input bit r, input bit v, input logic [7:0] c,
                     input logic [6:0] eo, input bit en, input string nm);
    vec_t t;
    t.r = r; t.v = v; t.c = c; t.eo = eo; t.en = en; t.nm = nm;
    tbl.push_back(t);
  endtask

  logic [7:0] pool [12];

  initial begin
    rst        = 1'b1;
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    idle_cnt   = 0;
    m_out      = 7'h00;
    m_new      = 1'b0;

    keymap[8'h1C] = 7'h61;  keymap[8'h23] = 7'h64;  keymap[8'h1D] = 7'h77;
    keymap[8'h1B] = 7'h73;  keymap[8'h29] = 7'h20;
    keymap[256 + 8'h6B] = 7'h61;  keymap[256 + 8'h74] = 7'h64;
    keymap[256 + 8'h75] = 7'h77;  keymap[256 + 8'h72] = 7'h73;

    // reset, with a strobe that must be ignored
    add(1, 0, 8'h00, 7'h00, 0, "reset");
    add(1, 1, 8'h1C, 7'h00, 0, "reset_strobe_ignored");
    // make / break of 'a'
    add(0, 1, 8'h1C, 7'h61, 1, "make_a");
    add(0, 0, 8'h00, 7'h61, 0, "make_a_single_pulse");
    add(0, 1, 8'hF0, 7'h61, 0, "brk_prefix_no_pulse");
    add(0, 1, 8'h1C, 7'h00, 1, "break_a");
    add(0, 0, 8'h00, 7'h00, 0, "break_a_single_pulse");
    // extended right arrow
    add(0, 1, 8'hE0, 7'h00, 0, "ext_prefix");
    add(0, 1, 8'h74, 7'h64, 1, "ext_make_right");
    add(0, 1, 8'hE0, 7'h64, 0, "ext_brk_prefix_e0");
    add(0, 1, 8'hF0, 7'h64, 0, "ext_brk_prefix_f0");
    add(0, 1, 8'h74, 7'h00, 1, "ext_break_right");
    add(0, 0, 8'h00, 7'h00, 0, "ext_idle");
    // two keys, last wins, break of the other key ignored
    add(0, 1, 8'h1C, 7'h61, 1, "two_make_a");
    add(0, 1, 8'h23, 7'h64, 1, "two_make_d");
    add(0, 1, 8'hF0, 7'h64, 0, "two_brk_prefix");
    add(0, 1, 8'h1C, 7'h64, 0, "two_break_a_ignored");
    add(0, 0, 8'h00, 7'h64, 0, "two_hold_d");
    add(0, 1, 8'h23, 7'h64, 1, "typematic_d");
    add(0, 1, 8'hF0, 7'h64, 0, "two_brk_prefix2");
    add(0, 1, 8'h23, 7'h00, 1, "two_break_d");
    // reset mid-sequence
    add(0, 1, 8'h23, 7'h64, 1, "rst_seq_make_d");
    add(0, 1, 8'hF0, 7'h64, 0, "rst_seq_prefix");
    add(1, 1, 8'h23, 7'h00, 0, "rst_seq_reset");
    add(0, 1, 8'h1C, 7'h61, 1, "rst_seq_make_after");
    // back-to-back and unmapped
    add(0, 1, 8'h29, 7'h20, 1, "b2b_space_1");
    add(0, 1, 8'h29, 7'h20, 1, "b2b_space_2");
    add(0, 0, 8'h00, 7'h20, 0, "b2b_idle");
    add(0, 1, 8'h15, 7'h20, 0, "unmapped_15");
    add(0, 0, 8'h00, 7'h20, 0, "unmapped_idle");
    add(0, 1, 8'hE0, 7'h20, 0, "ext_unmapped_prefix");
    add(0, 1, 8'h1C, 7'h20, 0, "ext_unmapped_1c");
    add(0, 1, 8'h6B, 7'h20, 0, "nonext_6b_unmapped");
    // malformed sequences
    add(0, 1, 8'hE0, 7'h20, 0, "mal_e0");
    add(0, 1, 8'hE0, 7'h20, 0, "mal_e0_e0");
    add(0, 1, 8'h75, 7'h77, 1, "mal_e0_e0_up");
    add(0, 1, 8'hF0, 7'h77, 0, "mal_f0");
    add(0, 1, 8'hE0, 7'h77, 0, "mal_f0_e0");
    add(0, 1, 8'h72, 7'h73, 1, "mal_f0_e0_down");
    add(0, 1, 8'hE0, 7'h73, 0, "mal_eb_e0");
    add(0, 1, 8'hF0, 7'h73, 0, "mal_eb_f0");
    add(0, 1, 8'hF0, 7'h73, 0, "mal_eb_f0_f0");
    add(0, 1, 8'h72, 7'h73, 0, "mal_eb_plain_72");
    add(0, 1, 8'hF0, 7'h73, 0, "alias_brk_prefix");
    add(0, 1, 8'h1B, 7'h00, 1, "alias_break_s_clears");

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].c);
      check(tbl[i].nm, tbl[i].eo, tbl[i].en);
    end

    // Timeout: strobe coinciding with expiry is still processed as a break.
    drive(1, 0, 8'h00);
    step("tmo_make_a", 1, 8'h1C, 7'h61, 1);
    step("tmo_prefix", 1, 8'hF0, 7'h61, 0);
    for (int i = 0; i < TMO - 1; i++) drive(0, 0, 8'h00);
    check("tmo_wait_hold", 7'h61, 0);
    step("tmo_strobe_wins", 1, 8'h1C, 7'h00, 1);

    // Timeout: after TMO idle cycles the F0 is discarded, 1C is a make.
    step("tmo2_prefix", 1, 8'hF0, 7'h00, 0);
    for (int i = 0; i < TMO; i++) drive(0, 0, 8'h00);
    check("tmo2_no_change", 7'h00, 0);
    step("tmo2_make_a", 1, 8'h1C, 7'h61, 1);

    // Timeout of E0: the following 74 is a plain (unmapped) byte.
    step("tmo3_prefix", 1, 8'hE0, 7'h61, 0);
    for (int i = 0; i < TMO; i++) drive(0, 0, 8'h00);
    step("tmo3_plain_74", 1, 8'h74, 7'h61, 0);

    // Randomized traffic against the model.
    pool = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h6B,
             8'h74, 8'h75, 8'h72, 8'hE0, 8'hF0, 8'h15};
    drive(1, 0, 8'h00);
    check("rand_reset", m_out, m_new);
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [7:0] c;
      if ($urandom_range(0, 39) == 0) begin
        int len;
        len = $urandom_range(TMO - 2, TMO + 2);
        for (int k = 0; k < len; k++) begin
          drive(0, 0, 8'h00);
          check("rand_idle", m_out, m_new);
        end
      end else if ($urandom_range(0, 199) == 0) begin
        drive(1, $urandom_range(0, 1) == 1, pool[$urandom_range(0, 11)]);
        check("rand_rst", m_out, m_new);
      end else begin
        sel = $urandom_range(0, 13);
        if (sel >= 12) c = 8'($urandom);
        else           c = pool[sel];
        drive(0, $urandom_range(0, 2) != 0, c);
        check("rand", m_out, m_new);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scancode_to_ascii.md
SCANCODE_TO_ASCII -- requirements
Module: scancode_to_ascii

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 40000, cycles a prefix state may wait for its follow-up byte before it is discarded (1 ms at 40 MHz).
REQ-002 Port: clk  input  1  system clock; all logic is on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: scan_code  input  8  PS/2 scan-code byte from the receiver; valid only when scan_valid=1.
REQ-005 Port: scan_valid  input  1  one-cycle strobe qualifying scan_code; back-to-back strobes are legal.
REQ-006 Port: ascii_out  output  7  ASCII code of the currently held key; 7'h00 when no mapped key is held.
REQ-007 Port: ascii_new  output  1  one-cycle pulse, high on every cycle in which ascii_out is (re)asserted or cleared.

Function
REQ-008 The block SHALL decode PS/2 set-2 make, break (F0) and extended (E0) sequences.
REQ-009 The FSM SHALL have exactly four states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-010 Transitions on scan_valid: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; any other byte completes a sequence and returns to IDLE.
REQ-011 Non-extended map: 1C->7'h61 'a', 23->7'h64 'd', 1D->7'h77 'w', 1B->7'h73 's', 29->7'h20 space.
REQ-012 Extended map: 6B (left arrow)->7'h61, 74 (right arrow)->7'h64, 75 (up)->7'h77, 72 (down)->7'h73.
REQ-013 Unmapped completing bytes SHALL return the FSM to IDLE with no change to either output.
REQ-014 A mapped make SHALL load ascii_out with the mapped code and pulse ascii_new, one cycle after the completing strobe.
REQ-015 A repeated make of the held key (typematic) SHALL re-pulse ascii_new with ascii_out unchanged.
REQ-016 A make of a different mapped key SHALL replace ascii_out (last key wins) and pulse ascii_new.
REQ-017 A mapped break whose code equals ascii_out SHALL clear ascii_out to 7'h00 and pulse ascii_new.
REQ-018 A mapped break of any other key SHALL leave both outputs unchanged.
REQ-019 A timeout counter SHALL reset on every strobe and count only while in EXT, BRK or EXT_BRK.
REQ-020 On reaching TIMEOUT_CYCLES-1 with no strobe, the FSM SHALL return to IDLE with outputs unchanged.
REQ-021 A strobe arriving in the same cycle as the timeout SHALL win; the byte is processed in the current state.
REQ-022 E0 in EXT, or E0/F0 in BRK or EXT_BRK, SHALL be treated as a malformed sequence: discard it and restart from IDLE as if that byte arrived in IDLE.
REQ-023 ascii_new SHALL never be high for two consecutive cycles unless two completing strobes arrive in consecutive cycles.
REQ-024 Both outputs SHALL be registered, with no combinational path from the inputs.

Reset
REQ-025 While rst=1: FSM=IDLE, ascii_out=7'h00, ascii_new=0, timeout counter=0.
REQ-026 Reset mid-sequence SHALL discard any pending prefix; the first byte after reset is decoded from IDLE.
REQ-027 scan_valid asserted during reset SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the state enum, the prefix constants (E0, F0), the scan-code constants and the ASCII constants.
REQ-029 One purely combinational sub-module, scan_lut, SHALL map {extended flag, scan_code} to {hit, ascii[6:0]}.
REQ-030 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES).

Verification
REQ-031 Make: strobe 1C -> next cycle ascii_out=61, ascii_new=1 for one cycle; then strobe F0,1C -> ascii_out=00 with one ascii_new pulse.
REQ-032 Extended: strobes E0,74 -> ascii_out=64; then E0,F0,74 -> ascii_out=00; no pulse on any prefix byte.
REQ-033 Two keys: make 1C, make 23, break 1C -> ascii_out=64 throughout after the second make; break 23 -> ascii_out=00.
REQ-034 Timeout: strobe F0, idle TIMEOUT_CYCLES cycles, strobe 1C -> treated as a make, ascii_out=61.
REQ-035 Reset mid-sequence: F0, rst for 1 cycle, then 1C -> ascii_out=61 with ascii_new=1.
REQ-036 Back-to-back and unmapped traffic: strobes 29,29 on consecutive cycles -> ascii_out=20 and ascii_new high 2 cycles; unmapped 15 -> no output change.
